dmem_bus_arbiter: RTL
=====================

Name: dmem_bus_arbiter

Overview:
- Shares the data-memory/peripheral bus between two requesters: master 0 (CPU load/store port) and master 1 (UART program/data loader).
- Serialises accesses through a 3-state FSM, muxes the address, data and strobes, and returns read data with a one-cycle ack pulse.
- Master 0 has fixed priority over master 1; a hold counter guarantees master 1 is not starved.
- Sits between the CPU datapath and the DataMem/Peripheral address decode.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_HOLD, 4, consecutive master-0 grants allowed while master 1 waits (range 1..15).

Ports:
- sysclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held until m0_ack.
- m0_wr  input  1  master 0 write (1) / read (0).
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_rdata  output  DATA_W  master 0 read data, registered.
- m0_ack  output  1  master 0 completion pulse, one cycle wide.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- mem_rd  output  1  bus read strobe.
- mem_wr  output  1  bus write strobe.
- mem_addr  output  ADDR_W  bus address.
- mem_wdata  output  DATA_W  bus write data.
- mem_rdata  input  DATA_W  bus read data, valid in the cycle after mem_rd.
- grant_id  output  1  owner of the current or last transfer.
- busy  output  1  high when the FSM is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0: acks, strobes, mem_addr, mem_wdata, both rdata registers, grant_id.
  - hold_cnt is cleared to 0.
  - Reset during ACCESS or RESP aborts the transfer with no ack.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise select a winner using the arbitration rule below.
  - Latch the winner's wr/addr/wdata into mem_addr/mem_wdata and set grant_id.
  - Set mem_rd=~wr or mem_wr=wr, then go to ACCESS.
- ACCESS:
  - Strobe is high for exactly this one cycle.
  - Next state is RESP; strobes drop to 0.
- RESP:
  - For a read, capture mem_rdata into the owner's rdata register.
  - Assert the owner's ack for this one cycle, then go to IDLE.
  - On a write, rdata is unchanged.
  - rdata holds its value until the owner's next read completes.
- Latency: req sampled in IDLE at edge N → strobe high in cycle N+1 → ack high in cycle N+2. Maximum throughput is one transfer per 3 cycles.
- Handshake:
  - A master keeps req/wr/addr/wdata stable until it samples its ack high.
  - Inputs are latched in IDLE only, so changes after the grant are ignored.
  - A req still high in the ack cycle is treated as a new request in the following IDLE.
- Arbitration:
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both: grant m1 if hold_cnt==MAX_HOLD, else grant m0.
- hold_cnt (4 bits, saturating at MAX_HOLD):
  - Increments on each m0 grant while m1_req=1.
  - Clears on any m1 grant, or in any IDLE cycle where m1_req=0.
- No simultaneous strobes: mem_rd & mem_wr is never 1.
- At most one ack is high per cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - hold_cnt is removed.
  - When both masters request, grant the master that was not the previous owner (last_grant flop, reset value 1, so m0 wins first).
  - Single requesters are granted as normal.
- Not defined: fixed priority with the MAX_HOLD starvation counter, as above.

Test Plan:
- Reset mid-transfer: m0 read at 0x00000010; pull reset low during ACCESS → m0_ack is never asserted, mem_rd=0 immediately, busy=0; after release, a fresh request completes normally.
- Single read: m0_req=1, m0_wr=0, m0_addr=0x00000020, mem_rdata=0xDEADBEEF → mem_rd high exactly one cycle with mem_addr=0x20; m0_ack in cycle N+2; m0_rdata=0xDEADBEEF.
- Single write: m1_req=1, m1_wr=1, m1_addr=0x40000008, m1_wdata=0x000000A5 → mem_wr one cycle with mem_wdata=0xA5; m1_ack in cycle N+2; m1_rdata unchanged; grant_id=1.
- Simultaneous requests: m0 and m1 raise req in the same cycle → m0 served first, m1 ack exactly 3 cycles after m0_ack.
- Starvation: m0_req held high continuously, m1_req high, MAX_HOLD=4 → four m0 acks, then one m1 ack, then m0 resumes; with ARB_ROUND_ROBIN_EN, acks strictly alternate m0,m1,m0,m1.
- Stability: change m0_addr to 0x44 during ACCESS after latching 0x20 → mem_addr stays 0x20; no mem_rd/mem_wr overlap and no dual acks across 200 random cycles.

Source files
------------

// File: rtl/dmem_bus_arbiter.sv
// Two-master data-memory bus arbiter: IDLE -> ACCESS -> RESP, registered strobes, rdata and acks.
// Build option ARB_ROUND_ROBIN_EN swaps the MAX_HOLD starvation counter for round-robin on contention.
module dmem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              cur_wr;
  logic              pick_m1;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Reset value 1 makes master 0 win the first contended grant.
  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req)
      pick_m1 = 1'b1;
    else if (m1_req && m0_req)
      pick_m1 = ~last_grant;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)
      last_grant <= 1'b1;
    else if (state == IDLE && (m0_req || m1_req))
      last_grant <= pick_m1;
  end
`else
  logic [3:0] hold_cnt;

  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req)
      pick_m1 = 1'b1;
    else if (m1_req && m0_req)
      pick_m1 = (hold_cnt == 4'(MAX_HOLD));
  end

  // Counts master-0 grants that overtook a waiting master 1; saturates at MAX_HOLD.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)
      hold_cnt <= '0;
    else if (state == IDLE) begin
      if (!m1_req || pick_m1)
        hold_cnt <= '0;
      else if (hold_cnt != 4'(MAX_HOLD))
        hold_cnt <= hold_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    sel_wr    = pick_m1 ? m1_wr    : m0_wr;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_wr    <= 1'b0;
      grant_id  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_id  <= pick_m1;
            cur_wr    <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_rd    <= ~sel_wr;
            mem_wr    <= sel_wr;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack is raised one edge early so it is high during RESP, when mem_rdata is valid.
          if (grant_id)
            m1_ack <= 1'b1;
          else
            m0_ack <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (!cur_wr) begin
            if (grant_id)
              m1_rdata <= mem_rdata;
            else
              m0_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
